// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make one-hot select driver for one NEM relay inverting mux.
// Latency: accept->CUR_VALID is T_MAKE+1 cycles from all-off, T_BREAK+T_MAKE+1 from a connected path.
// Backpressure: REQ_READY is high only in IDLE; a request held during a sequence is taken on the first IDLE cycle.
// Optional: define NEM_SEL_BOOST_EN to add S_BOOST (high during MAKE/SETTLE for elevated pull-in voltage).
module nem_ohmux_sel_ctrl #(
  parameter int N_IN    = 4,
  parameter int SEL_W   = 2,
  parameter int T_BREAK = 4,
  parameter int T_MAKE  = 8
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [SEL_W-1:0] REQ_SEL,
  input  logic             REQ_OFF,
  output logic [N_IN-1:0]  S,
  output logic [SEL_W-1:0] CUR_SEL,
  output logic             CUR_VALID,
  output logic             BUSY,
  output logic             ERR
`ifdef NEM_SEL_BOOST_EN
  ,
  output logic             S_BOOST
`endif
);

  // Counter sized to hold the longer of the two timed phases.
  localparam int T_MAX = (T_BREAK > T_MAKE) ? T_BREAK : T_MAKE;
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] BREAK_LOAD = CNT_W'(T_BREAK - 1);
  localparam logic [CNT_W-1:0] MAKE_LOAD  = CNT_W'(T_MAKE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // N_IN always fits in SEL_W+1 bits because 2**SEL_W >= N_IN.
  localparam logic [SEL_W:0]   N_IN_W     = (SEL_W + 1)'(N_IN);
  localparam logic [N_IN-1:0]  S_ONE      = {{(N_IN - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BREAK  = 2'd1,
    ST_MAKE   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [SEL_W-1:0] hold_sel_q,  hold_sel_d;
  logic             hold_off_q,  hold_off_d;
  logic [N_IN-1:0]  s_q,         s_d;
  logic [SEL_W-1:0] cur_sel_q,   cur_sel_d;
  logic             cur_valid_q, cur_valid_d;
  logic             busy_q,      busy_d;
  logic             err_q,       err_d;
`ifdef NEM_SEL_BOOST_EN
  logic             boost_q,     boost_d;
`endif

  logic acc;
  logic sel_oob;
  logic same_sel;

  // Handshake qualifiers for the request presented this cycle.
  always_comb begin
    acc      = REQ_VALID && (state_q == ST_IDLE);
    sel_oob  = ({1'b0, REQ_SEL} >= N_IN_W);
    same_sel = cur_valid_q && (REQ_SEL == cur_sel_q);
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_sel_q  <= '0;
      hold_off_q  <= 1'b0;
      s_q         <= '0;
      cur_sel_q   <= '0;
      cur_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef NEM_SEL_BOOST_EN
      boost_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_sel_q  <= hold_sel_d;
      hold_off_q  <= hold_off_d;
      s_q         <= s_d;
      cur_sel_q   <= cur_sel_d;
      cur_valid_q <= cur_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef NEM_SEL_BOOST_EN
      boost_q     <= boost_d;
`endif
    end
  end

  // Next-state: sequence IDLE -> [BREAK] -> MAKE -> SETTLE -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_sel_d = hold_sel_q;
    hold_off_d = hold_off_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          hold_sel_d = REQ_SEL;
          hold_off_d = REQ_OFF;
          if (!REQ_OFF && (sel_oob || same_sel)) begin
            // Rejected index or already connected: nothing to switch.
            state_d = ST_IDLE;
          end else if (s_q != '0) begin
            // A relay is actuated: release it before anything else.
            state_d = ST_BREAK;
            cnt_d   = BREAK_LOAD;
          end else if (!REQ_OFF) begin
            // Nothing to release, pull the new relay in directly.
            state_d = ST_MAKE;
          end
        end
      end
      ST_BREAK: begin
        if (cnt_q == '0) begin
          state_d = hold_off_q ? ST_IDLE : ST_MAKE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_MAKE: begin
        state_d = ST_SETTLE;
        cnt_d   = MAKE_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next-values; S only moves onehot->0 (entering BREAK) or 0->onehot (in MAKE).
  always_comb begin
    s_d         = s_q;
    cur_sel_d   = cur_sel_q;
    cur_valid_d = cur_valid_q;
    err_d       = 1'b0;
    busy_d      = (state_d != ST_IDLE);
`ifdef NEM_SEL_BOOST_EN
    boost_d     = (state_d == ST_MAKE) || (state_d == ST_SETTLE);
`endif
    case (state_q)
      ST_IDLE: begin
        err_d = acc && !REQ_OFF && sel_oob;
        if (state_d == ST_BREAK) begin
          s_d         = '0;
          cur_valid_d = 1'b0;
        end
      end
      ST_MAKE: begin
        s_d = S_ONE << hold_sel_q;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          cur_sel_d   = hold_sel_q;
          cur_valid_d = 1'b1;
        end
      end
      default: begin
        s_d = s_q;
      end
    endcase
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign S         = s_q;
  assign CUR_SEL   = cur_sel_q;
  assign CUR_VALID = cur_valid_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
`ifdef NEM_SEL_BOOST_EN
  assign S_BOOST   = boost_q;
`endif

endmodule
